sensor_burst_reader: RTL and testbench

- Parametrised multi-channel sensor sampler. Sits between the I2C byte engine and downstream angle/filter logic.
- After an optional one-byte init write to the sensor, it periodically burst-reads NUM_CH consecutive big-endian 16-bit registers starting at BASE_ADDR, one byte per engine transaction.
- Publishes each complete frame atomically with a one-cycle valid strobe.
- Adds timeout and error recovery.

---
 rtl/sensor_burst_reader.sv | 123 ++++++++++++
 tb/tb_sensor_burst_reader.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/sensor_burst_reader.sv
// sensor_burst_reader: periodic NUM_CH x 16-bit big-endian burst sampler over a byte-wide I2C engine,
// with optional init write, per-transaction timeout and atomic frame publish.
module sensor_burst_reader #(
    parameter int         NUM_CH     = 3,
    parameter logic [7:0] BASE_ADDR  = 8'h3B,
    parameter int         SAMPLE_DIV = 100000,
    parameter bit         INIT_EN    = 1'b1,
    parameter logic [7:0] INIT_REG   = 8'h6B,
    parameter logic [7:0] INIT_VAL   = 8'h00,
    parameter int         TIMEOUT    = 65535
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    output logic                  i2c_start,
    output logic                  i2c_we,
    output logic [7:0]            i2c_addr,
    output logic [7:0]            i2c_wdata,
    input  logic                  i2c_done,
    input  logic                  i2c_err,
    input  logic [7:0]            i2c_rdata,
    output logic [16*NUM_CH-1:0]  sample_data,
    output logic                  sample_valid,
    output logic                  busy,
    output logic                  error
);
    localparam int NB = 2 * NUM_CH;
    localparam int IW = $clog2(NB);
    localparam int CW = $clog2(SAMPLE_DIV);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_INIT_ISSUE = 3'd1;
    localparam logic [2:0] S_INIT_WAIT  = 3'd2;
    localparam logic [2:0] S_WAIT_TICK  = 3'd3;
    localparam logic [2:0] S_RD_ISSUE   = 3'd4;
    localparam logic [2:0] S_RD_WAIT    = 3'd5;
    localparam logic [2:0] S_COMMIT     = 3'd6;

    logic [2:0]           state_q, state_d;
    logic [CW-1:0]        cnt_q;
    logic [TW-1:0]        to_q;
    logic [IW-1:0]        idx_q, idx_d;
    logic                 pend_q, err_q, we_q;
    logic [7:0]           addr_q, wdata_q;
    logic [NB-1:0][7:0]   shadow_q, data_q, frame;
    logic                 tick, waiting, timeout, ok, bad, last;

    assign tick    = enable && cnt_q == CW'(SAMPLE_DIV - 1);
    assign waiting = state_q == S_INIT_WAIT || state_q == S_RD_WAIT;
    assign timeout = !i2c_done && to_q == TW'(TIMEOUT - 1);
    assign ok      = i2c_done && !i2c_err;
    assign bad     = (i2c_done && i2c_err) || timeout;
    assign last    = idx_q == IW'(NB - 1);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:       if (enable) state_d = INIT_EN ? S_INIT_ISSUE : S_WAIT_TICK;
            S_INIT_ISSUE: state_d = S_INIT_WAIT;
            S_INIT_WAIT:  if (ok || bad) state_d = S_WAIT_TICK;
            S_WAIT_TICK:  if (!enable) state_d = S_IDLE;
                          else if (tick) state_d = pend_q ? S_INIT_ISSUE : S_RD_ISSUE;
            S_RD_ISSUE:   state_d = S_RD_WAIT;
            S_RD_WAIT:    if (ok) state_d = last ? S_COMMIT : S_RD_ISSUE;
                          else if (bad) state_d = S_WAIT_TICK;
            S_COMMIT:     state_d = enable ? S_WAIT_TICK : S_IDLE;
            default:      state_d = S_IDLE;
        endcase
    end

    always_comb begin
        idx_d = state_q == S_WAIT_TICK ? '0 :
                (state_q == S_RD_WAIT && ok && !last) ? idx_q + 1'b1 : idx_q;
        // Even byte index is the high byte, so swapping bit 0 maps it onto the packed byte lane.
        frame = shadow_q;
        frame[idx_q ^ IW'(1)] = i2c_rdata;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            to_q     <= '0;
            idx_q    <= '0;
            pend_q   <= 1'b0;
            err_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            shadow_q <= '0;
            data_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= (!enable || tick) ? '0 : cnt_q + 1'b1;
            to_q    <= waiting ? to_q + 1'b1 : '0;
            if (state_q == S_IDLE && enable) pend_q <= INIT_EN;
            else if (state_q == S_INIT_WAIT && ok) pend_q <= 1'b0;
            if (state_d == S_INIT_ISSUE) begin
                we_q    <= 1'b1;
                addr_q  <= INIT_REG;
                wdata_q <= INIT_VAL;
            end else if (state_d == S_RD_ISSUE) begin
                we_q    <= 1'b0;
                addr_q  <= BASE_ADDR + 8'(idx_d);
                wdata_q <= '0;
            end
            if (state_q == S_RD_WAIT && ok) shadow_q <= frame;
            if (state_q == S_RD_WAIT && ok && last) data_q <= frame;
            if (waiting && bad) err_q <= 1'b1;
            else if (state_q == S_RD_WAIT && ok && last) err_q <= 1'b0;
        end
    end

    assign i2c_start    = state_q == S_INIT_ISSUE || state_q == S_RD_ISSUE;
    assign i2c_we       = we_q;
    assign i2c_addr     = addr_q;
    assign i2c_wdata    = wdata_q;
    assign sample_data  = data_q;
    assign sample_valid = state_q == S_COMMIT;
    assign busy         = !(state_q == S_IDLE || state_q == S_WAIT_TICK);
    assign error        = err_q;
endmodule

// File: tb/tb_sensor_burst_reader.sv
// tb_sensor_burst_reader: randomized register file behind a fixed-latency engine model, checked against frame/timing rules.
module tb_sensor_burst_reader;
    localparam int NCH = 3, DIV = 64, TMO = 32, LAT = 3;
    localparam logic [7:0] BASE = 8'h3B;

    logic clock = 1'b0, reset = 1'b1, enable = 1'b0;
    logic i2c_start, i2c_we, i2c_done, i2c_err;
    logic [7:0] i2c_addr, i2c_wdata, i2c_rdata;
    logic [16*NCH-1:0] sample_data;
    logic sample_valid, busy, error;

    int checks = 0, errors = 0, cyc = 0, nvalid = 0, v_cyc = 0, stab_bad = 0;
    logic [7:0] mem [256];
    logic [7:0] tx_addr [$];
    logic [7:0] tx_wdata [$];
    logic       tx_we [$];
    int         tx_cyc [$];
    bit mute = 1'b0, nack_arm = 1'b0, pending = 1'b0, p_we;
    logic [7:0] p_addr;
    int left;

    sensor_burst_reader #(.NUM_CH(NCH), .SAMPLE_DIV(DIV), .TIMEOUT(TMO)) dut (
        .clock(clock), .reset(reset), .enable(enable),
        .i2c_start(i2c_start), .i2c_we(i2c_we), .i2c_addr(i2c_addr), .i2c_wdata(i2c_wdata),
        .i2c_done(i2c_done), .i2c_err(i2c_err), .i2c_rdata(i2c_rdata),
        .sample_data(sample_data), .sample_valid(sample_valid), .busy(busy), .error(error)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Engine: logs every request, answers LAT cycles later with the register file byte.
    initial begin
        i2c_done = 1'b0;
        i2c_err = 1'b0;
        i2c_rdata = 8'h00;
        forever begin
            @(negedge clock);
            i2c_done = 1'b0;
            i2c_err = 1'b0;
            if (reset) begin
                pending = 1'b0;
                continue;
            end
            if (pending) begin
                if (i2c_addr !== p_addr || i2c_we !== p_we) stab_bad++;
                left--;
                if (left == 0) begin
                    pending = 1'b0;
                    i2c_done = 1'b1;
                    i2c_rdata = mem[p_addr];
                    if (nack_arm && !p_we && p_addr == BASE + 8'd3) begin
                        i2c_err = 1'b1;
                        nack_arm = 1'b0;
                    end
                end
            end
            if (i2c_start === 1'b1) begin
                tx_addr.push_back(i2c_addr);
                tx_we.push_back(i2c_we);
                tx_wdata.push_back(i2c_wdata);
                tx_cyc.push_back(cyc);
                if (!mute) begin
                    pending = 1'b1;
                    left = LAT;
                    p_addr = i2c_addr;
                    p_we = i2c_we;
                end
            end
            if (sample_valid === 1'b1) begin
                nvalid++;
                v_cyc = cyc;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #2;
        end
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n0 = nvalid;
        int k = 0;
        while (nvalid == n0 && k < budget) begin
            step(1);
            k++;
        end
        chk({tag, "_valid_seen"}, 64'(nvalid != n0), 64'd1);
    endtask

    task automatic wait_tx(input string tag, input int cnt, input int budget);
        int k = 0;
        while (tx_addr.size() < cnt && k < budget) begin
            step(1);
            k++;
        end
        chk({tag, "_tx_seen"}, 64'(tx_addr.size() >= cnt), 64'd1);
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_start"}, 64'(i2c_start), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_valid"}, 64'(sample_valid), 64'd0);
        chk({tag, "_error"}, 64'(error), 64'd0);
        chk({tag, "_data"}, 64'(sample_data), 64'd0);
        chk({tag, "_addr"}, 64'(i2c_addr), 64'd0);
        chk({tag, "_we"}, 64'(i2c_we), 64'd0);
        chk({tag, "_wdata"}, 64'(i2c_wdata), 64'd0);
    endtask

    task automatic rnd();
        for (int i = 0; i < 2 * NCH; i++) mem[BASE + 8'(i)] = 8'($urandom);
    endtask

    function automatic logic [16*NCH-1:0] exp_frame();
        logic [16*NCH-1:0] f = '0;
        for (int k = 0; k < NCH; k++) f[16*k +: 16] = {mem[BASE + 8'(2*k)], mem[BASE + 8'(2*k+1)]};
        return f;
    endfunction

    initial begin
        logic [16*NCH-1:0] exp_prev;
        int n, n0, s, e, k, prev_start;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        {mem[8'h3B], mem[8'h3C], mem[8'h3D], mem[8'h3E], mem[8'h3F], mem[8'h40]} = 48'h12_34_56_78_9A_BC;
        step(3);
        reset_checks("por");
        reset = 1'b0;
        step(2);
        enable = 1'b1;
        e = cyc;
        wait_valid("frame0", 200);
        chk("init_we", 64'(tx_we[0]), 64'd1);
        chk("init_addr", 64'(tx_addr[0]), 64'h6B);
        chk("init_wdata", 64'(tx_wdata[0]), 64'h00);
        chk("first_read_at_tick", 64'(tx_cyc[1] - e), 64'(DIV));
        for (int i = 0; i < 2 * NCH; i++) begin
            chk("rd_addr", 64'(tx_addr[i+1]), 64'(BASE + 8'(i)));
            chk("rd_we", 64'(tx_we[i+1]), 64'd0);
        end
        chk("frame0_const", 64'(sample_data), 64'h9ABC_5678_1234);
        chk("frame0_model", 64'(sample_data), 64'(exp_frame()));
        chk("frame0_latency", 64'(v_cyc - tx_cyc[1]), 64'(2 * NCH * (1 + LAT)));
        chk("frame0_count", 64'(nvalid), 64'd1);
        prev_start = tx_cyc[1];
        exp_prev = exp_frame();
        for (int f = 0; f < 3; f++) begin
            rnd();
            n = tx_addr.size();
            wait_valid("period", 150);
            chk("period_gap", 64'(tx_cyc[n] - prev_start), 64'(DIV));
            chk("period_addr", 64'(tx_addr[n]), 64'(BASE));
            chk("period_data", 64'(sample_data), 64'(exp_frame()));
            exp_prev = exp_frame();
            prev_start = tx_cyc[n];
            step(5);
            chk("gap_busy", 64'(busy), 64'd0);
            chk("gap_start", 64'(i2c_start), 64'd0);
        end
        rnd();
        n0 = nvalid;
        nack_arm = 1'b1;
        k = 0;
        while (!error && k < 150) begin
            step(1);
            k++;
        end
        chk("nack_error", 64'(error), 64'd1);
        chk("nack_no_valid", 64'(nvalid), 64'(n0));
        chk("nack_data_held", 64'(sample_data), 64'(exp_prev));
        wait_valid("nack_retry", 150);
        chk("nack_retry_data", 64'(sample_data), 64'(exp_frame()));
        chk("nack_retry_error", 64'(error), 64'd0);
        rnd();
        mute = 1'b1;
        n = tx_addr.size();
        wait_tx("to_start", n + 1, 100);
        s = tx_cyc[n];
        chk("to_first_addr", 64'(tx_addr[n]), 64'(BASE));
        k = 0;
        while (!error && k < 100) begin
            step(1);
            k++;
        end
        chk("to_error_cycle", 64'(cyc - s), 64'(TMO + 1));
        mute = 1'b0;
        wait_tx("to_retry", n + 2, 100);
        chk("to_retry_addr", 64'(tx_addr[n+1]), 64'(BASE));
        chk("to_retry_tick", 64'(tx_cyc[n+1] - s), 64'(DIV));
        wait_valid("to_retry", 100);
        chk("to_retry_data", 64'(sample_data), 64'(exp_frame()));
        chk("to_retry_error", 64'(error), 64'd0);
        rnd();
        n = tx_addr.size();
        wait_tx("mid", n + 3, 100);
        enable = 1'b0;
        n0 = nvalid;
        wait_valid("mid_frame", 100);
        chk("mid_data", 64'(sample_data), 64'(exp_frame()));
        step(2);
        chk("mid_idle_busy", 64'(busy), 64'd0);
        n = tx_addr.size();
        step(150);
        chk("idle_no_tx", 64'(tx_addr.size()), 64'(n));
        chk("idle_one_valid", 64'(nvalid), 64'(n0 + 1));
        enable = 1'b1;
        n = tx_addr.size();
        wait_tx("reinit", n + 1, 20);
        chk("reinit_we", 64'(tx_we[n]), 64'd1);
        chk("reinit_addr", 64'(tx_addr[n]), 64'h6B);
        wait_tx("reinit_rd", n + 2, 100);
        chk("pre_reset_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        #1;
        reset_checks("mid_reset");
        step(2);
        reset = 1'b0;
        step(2);
        chk("addr_stable", 64'(stab_bad), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
